// File: rtl/wb_bram_arbiter_if.sv
// Initiator-side Wishbone wires and BRAM macro pins for wb_bram_arbiter.
// The slave modport is the arbiter's view; the master modport is the initiators'/BRAM's view.
`timescale 1ns/1ps
interface wb_bram_arbiter_if #(
  parameter int N_INITIATORS = 2,
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 32
);
  localparam int SEL_W = DATA_WIDTH / 8;

  logic [N_INITIATORS*32-1:0]         i_adr;
  logic [N_INITIATORS*DATA_WIDTH-1:0] i_dat_w;
  logic [N_INITIATORS*SEL_W-1:0]      i_sel;
  logic [N_INITIATORS-1:0]            i_we;
  logic [N_INITIATORS-1:0]            i_cyc;
  logic [N_INITIATORS-1:0]            i_stb;
  logic [DATA_WIDTH-1:0]              i_dat_r;
  logic [N_INITIATORS-1:0]            i_ack;
  logic [N_INITIATORS-1:0]            gnt;
  logic [ADDR_WIDTH-1:0]              bram_adr;
  logic [SEL_W-1:0]                   bram_sel;
  logic                               bram_we;
  logic [DATA_WIDTH-1:0]              bram_dat_w;
  logic [DATA_WIDTH-1:0]              bram_dat_r;

  modport slave (
    input  i_adr, i_dat_w, i_sel, i_we, i_cyc, i_stb, bram_dat_r,
    output i_dat_r, i_ack, gnt, bram_adr, bram_sel, bram_we, bram_dat_w
  );

  modport master (
    output i_adr, i_dat_w, i_sel, i_we, i_cyc, i_stb, bram_dat_r,
    input  i_dat_r, i_ack, gnt, bram_adr, bram_sel, bram_we, bram_dat_w
  );
endinterface

// File: rtl/wb_bram_arbiter.sv
// Round-robin Wishbone arbiter driving a single synchronous BRAM port (ACCESS then ACK per beat).
// Optional owner idle-timeout revocation is built when WB_BRAM_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module wb_bram_arbiter #(
  parameter int N_INITIATORS = 2,
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 32,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  wb_bram_arbiter_if.slave bus
);
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1;

  // IDLE: no owner | ACCESS: owner address phase | ACK: data phase, ack to owner
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  logic [1:0]              r_state;
  logic [IDX_W-1:0]        r_last;
  logic [IDX_W-1:0]        r_owner;
  logic [N_INITIATORS-1:0] r_gnt;

  logic                    w_own_cyc, w_own_stb, w_own_we;
  logic [ADDR_WIDTH-1:0]   w_own_wadr;
  logic [DATA_WIDTH-1:0]   w_own_dat;
  logic [SEL_W-1:0]        w_own_sel;
  logic                    w_unused;

  assign w_unused = &{1'b0, bus.i_adr, 8'(IDLE_TIMEOUT)};

  always_comb begin
    w_own_cyc  = 1'b0;
    w_own_stb  = 1'b0;
    w_own_we   = 1'b0;
    w_own_wadr = '0;
    w_own_dat  = '0;
    w_own_sel  = '0;
    for (int k = 0; k < N_INITIATORS; k++) begin
      if (r_owner == IDX_W'(k)) begin
        w_own_cyc  = bus.i_cyc[k];
        w_own_stb  = bus.i_stb[k];
        w_own_we   = bus.i_we[k];
        w_own_wadr = bus.i_adr[k*32+2 +: ADDR_WIDTH];
        w_own_dat  = bus.i_dat_w[k*DATA_WIDTH +: DATA_WIDTH];
        w_own_sel  = bus.i_sel[k*SEL_W +: SEL_W];
      end
    end
  end

  // Rotating priority: lowest requester above r_last wins, else lowest at or below it.
  logic                    w_hi_valid, w_lo_valid;
  logic [IDX_W-1:0]        w_hi, w_lo, w_pick;
  logic [N_INITIATORS-1:0] w_pick_oh;

  always_comb begin
    w_hi_valid = 1'b0;
    w_lo_valid = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int k = N_INITIATORS - 1; k >= 0; k--) begin
      if (bus.i_cyc[k]) begin
        if (IDX_W'(k) > r_last) begin
          w_hi_valid = 1'b1;
          w_hi       = IDX_W'(k);
        end else begin
          w_lo_valid = 1'b1;
          w_lo       = IDX_W'(k);
        end
      end
    end
    w_pick = w_hi_valid ? w_hi : w_lo;
    for (int k = 0; k < N_INITIATORS; k++) begin
      w_pick_oh[k] = (w_pick == IDX_W'(k));
    end
  end

`ifdef WB_BRAM_ARB_TIMEOUT_EN
  logic [7:0] r_idle_cnt;
  logic       w_timeout;
  assign w_timeout = ((r_idle_cnt + 8'd1) == 8'(IDLE_TIMEOUT));
`endif

  logic [1:0] w_next;
  logic       w_grant, w_release;

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((|bus.i_cyc) && (w_hi_valid || w_lo_valid)) begin
          w_grant = 1'b1;
          w_next  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!w_own_cyc)     w_release = 1'b1;
        else if (w_own_stb) w_next    = S_ACK;
`ifdef WB_BRAM_ARB_TIMEOUT_EN
        else if (w_timeout) w_release = 1'b1;
`endif
      end
      S_ACK: begin
        if (w_own_cyc) w_next    = S_ACCESS;
        else           w_release = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_release) w_next = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_last  <= IDX_W'(N_INITIATORS - 1);
      r_owner <= '0;
      r_gnt   <= '0;
`ifdef WB_BRAM_ARB_TIMEOUT_EN
      r_idle_cnt <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner <= w_pick;
        r_gnt   <= w_pick_oh;
      end
      if (w_release) begin
        r_last <= r_owner;
        r_gnt  <= '0;
      end
`ifdef WB_BRAM_ARB_TIMEOUT_EN
      if (r_state == S_ACCESS && w_own_cyc && !w_own_stb && !w_timeout)
        r_idle_cnt <= r_idle_cnt + 8'd1;
      else
        r_idle_cnt <= '0;
`endif
    end
  end

  logic [ADDR_WIDTH-1:0]   w_bram_adr;
  logic [SEL_W-1:0]        w_bram_sel;
  logic                    w_bram_we;
  logic [DATA_WIDTH-1:0]   w_bram_dat_w;
  logic [DATA_WIDTH-1:0]   w_dat_r;
  logic [N_INITIATORS-1:0] w_ack;

  always_comb begin
    w_bram_adr   = '0;
    w_bram_sel   = '0;
    w_bram_we    = 1'b0;
    w_bram_dat_w = '0;
    w_dat_r      = '0;
    w_ack        = '0;
    if (r_state == S_ACCESS && w_own_cyc && w_own_stb) begin
      w_bram_adr   = w_own_wadr;
      w_bram_sel   = w_own_sel;
      w_bram_we    = w_own_we;
      w_bram_dat_w = w_own_dat;
    end
    if (r_state == S_ACK) begin
      w_ack   = r_gnt & {N_INITIATORS{w_own_cyc}};
      w_dat_r = bus.bram_dat_r;
    end
  end

  assign bus.bram_adr   = w_bram_adr;
  assign bus.bram_sel   = w_bram_sel;
  assign bus.bram_we    = w_bram_we;
  assign bus.bram_dat_w = w_bram_dat_w;
  assign bus.i_dat_r    = w_dat_r;
  assign bus.i_ack      = w_ack;
  assign bus.gnt        = r_gnt;
endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Testbench for wb_bram_arbiter: BRAM model, vector table of single accesses, ack scoreboard,
// plus hand-written contention, abandon, reset and idle-owner sequences.
`timescale 1ns/1ps
module tb_wb_bram_arbiter;
  localparam int N  = 2;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clock = 1'b0;
  logic reset;
  logic preload;

  always #5 clock = ~clock;

  wb_bram_arbiter_if #(.N_INITIATORS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_bram_arbiter #(
    .N_INITIATORS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDLE_TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 4) ? 32'hDEAD_BEEF : {b, b, b, b};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // synchronous BRAM: read data valid the cycle after the address is sampled
  logic [31:0] mem [256];
  logic [31:0] r_rd;
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bus.bram_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.bram_sel[b]) mem[bus.bram_adr[7:0]][b*8 +: 8] <= bus.bram_dat_w[b*8 +: 8];
    end
    r_rd <= mem[bus.bram_adr[7:0]];
  end
  assign bus.bram_dat_r = r_rd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          init;
    bit          rd;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];
  sb_t e_mon;
  logic [31:0] ref_mem [256];

  always @(negedge clock) begin
    if (reset === 1'b1 && bus.i_ack !== '0) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 64'(bus.i_ack), 64'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("ack_owner", 64'(bus.i_ack), 64'd1 << e_mon.init);
        if (e_mon.rd) chk("rd_data", 64'(bus.i_dat_r), 64'(e_mon.data));
      end
    end
  end

  typedef struct {
    int          init;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [23:0] badr;
  } vec_t;
  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int k, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit cyc, input bit stb);
    bus.i_adr[k*32 +: 32]   = adr;
    bus.i_dat_w[k*32 +: 32] = dat;
    bus.i_sel[k*4 +: 4]     = sel;
    bus.i_we[k]             = we;
    bus.i_cyc[k]            = cyc;
    bus.i_stb[k]            = stb;
  endtask

  task automatic release_m(input int k);
    drive(k, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic expect_push(input int k, input bit we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
    logic [7:0] w;
    w = adr[9:2];
    if (we) begin
      ref_mem[w] = merge(ref_mem[w], dat, sel);
      sb.push_back('{k, 1'b0, 32'h0});
    end else begin
      sb.push_back('{k, 1'b1, ref_mem[w]});
    end
  endtask

  task automatic do_access(input vec_t v);
    logic [1:0] oh;
    oh = '0;
    oh[v.init] = 1'b1;
    tick();
    drive(v.init, v.we, v.adr, v.dat, v.sel, 1'b1, 1'b1);
    expect_push(v.init, v.we, v.adr, v.dat, v.sel);
    @(negedge clock);
    chk("c0_gnt", 64'(bus.gnt), 64'd0);
    chk("c0_we", 64'(bus.bram_we), 64'd0);
    tick();
    @(negedge clock);
    chk("c1_gnt", 64'(bus.gnt), 64'(oh));
    chk("c1_bram_adr", 64'(bus.bram_adr), 64'(v.badr));
    chk("c1_bram_we", 64'(bus.bram_we), 64'(v.we));
    chk("c1_bram_sel", 64'(bus.bram_sel), 64'(v.sel));
    chk("c1_bram_dat_w", 64'(bus.bram_dat_w), 64'(v.dat));
    chk("c1_ack", 64'(bus.i_ack), 64'd0);
    tick();
    @(negedge clock);
    chk("c2_ack", 64'(bus.i_ack), 64'(oh));
    chk("c2_bram_we", 64'(bus.bram_we), 64'd0);
    chk("c2_bram_adr", 64'(bus.bram_adr), 64'd0);
    tick();
    release_m(v.init);
    @(negedge clock);
    chk("c3_ack", 64'(bus.i_ack), 64'd0);
  endtask

  task automatic wait_ack_drop(input int k);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clock);
      if (bus.i_ack[k] === 1'b1) got = 1'b1;
      else tick();
    end
    chk("ack_wait", 64'(got), 64'd1);
    tick();
    release_m(k);
  endtask

  task automatic run_both(input int first, input int nacc, input logic [31:0] base);
    int left[2];
    bit ackd[2];
    int budget;
    for (int r = 0; r < 2; r++) begin
      int k;
      k = (r == 0) ? first : 1 - first;
      for (int j = 0; j < nacc; j++)
        expect_push(k, 1'b0, base + 32'(k*64 + j*4), 32'h0, 4'hF);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, base + 32'(k*64), 32'h0, 4'hF, 1'b1, 1'b1);
      left[k] = nacc;
    end
    budget = 0;
    while ((left[0] > 0 || left[1] > 0) && budget < 64) begin
      @(negedge clock);
      ackd[0] = (bus.i_ack[0] === 1'b1);
      ackd[1] = (bus.i_ack[1] === 1'b1);
      tick();
      budget++;
      for (int k = 0; k < 2; k++) begin
        if (ackd[k] && left[k] > 0) begin
          left[k]--;
          if (left[k] == 0) release_m(k);
          else drive(k, 1'b0, base + 32'(k*64 + (nacc - left[k])*4), 32'h0, 4'hF, 1'b1, 1'b1);
        end
      end
    end
    chk("both_done", 64'(left[0] + left[1]), 64'd0);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 24'h4};
    vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 24'h8};
    vecs[2] = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 24'h8};
    vecs[3] = '{1, 1'b0, 32'hFC00_0013, 32'h0,         4'hF, 24'h4};
    vecs[4] = '{0, 1'b1, 32'h0000_003C, 32'hCAFE_F00D, 4'hF, 24'hF};
    vecs[5] = '{1, 1'b0, 32'h0000_003C, 32'h0,         4'hF, 24'hF};
    vecs[6] = '{0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'hC, 24'h4};
    vecs[7] = '{1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 24'h4};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    reset       = 1'b0;
    preload     = 1'b1;
    bus.i_adr   = '0;
    bus.i_dat_w = '0;
    bus.i_sel   = '0;
    bus.i_we    = '0;
    bus.i_cyc   = '0;
    bus.i_stb   = '0;
    repeat (2) @(posedge clock);
    #1;
    preload = 1'b0;
    @(negedge clock);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_ack", 64'(bus.i_ack), 64'd0);
    chk("rst_bram_we", 64'(bus.bram_we), 64'd0);
    chk("rst_bram_adr", 64'(bus.bram_adr), 64'd0);
    chk("rst_bram_sel", 64'(bus.bram_sel), 64'd0);
    chk("rst_bram_dat_w", 64'(bus.bram_dat_w), 64'd0);
    chk("rst_dat_r", 64'(bus.i_dat_r), 64'd0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 8; i++) do_access(vecs[i]);

    // contention right after reset: init0 first, both accesses locked
    do_reset();
    run_both(0, 2, 32'h80);
    // init0 served last, so init1 wins the next contention
    do_access(vecs[0]);
    run_both(1, 2, 32'h100);

    // abandon: init0 drops cyc during ACK while init1 waits
    tick();
    drive(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b1);
    tick();
    drive(1, 1'b0, 32'h3C, 32'h0, 4'hF, 1'b1, 1'b1);
    expect_push(1, 1'b0, 32'h3C, 32'h0, 4'hF);
    @(negedge clock);
    chk("ab_gnt_owner", 64'(bus.gnt), 64'd1);
    tick();
    release_m(0);
    @(negedge clock);
    chk("ab_no_ack", 64'(bus.i_ack), 64'd0);
    tick();
    @(negedge clock);
    chk("ab_idle_gnt", 64'(bus.gnt), 64'd0);
    tick();
    @(negedge clock);
    chk("ab_handover_gnt", 64'(bus.gnt), 64'd2);
    wait_ack_drop(1);

    // reset during ACK of a write: write lands, no ack, arbiter idle
    tick();
    tick();
    drive(0, 1'b1, 32'h40, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b1);
    ref_mem[16] = 32'h5A5A_5A5A;
    tick();
    @(negedge clock);
    chk("rm_bram_we", 64'(bus.bram_we), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    release_m(0);
    @(negedge clock);
    chk("rm_ack", 64'(bus.i_ack), 64'd0);
    chk("rm_gnt", 64'(bus.gnt), 64'd0);
    chk("rm_bram_we", 64'(bus.bram_we), 64'd0);
    chk("rm_dat_r", 64'(bus.i_dat_r), 64'd0);
    do_access('{1, 1'b0, 32'h40, 32'h0, 4'hF, 24'h10});

    // idle owner: init0 holds cyc without stb while init1 requests
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0);
    tick();
    drive(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b1);
    expect_push(1, 1'b0, 32'h10, 32'h0, 4'hF);
    @(negedge clock);
    chk("to_gnt_c1", 64'(bus.gnt), 64'd1);
`ifdef WB_BRAM_ARB_TIMEOUT_EN
    for (int c = 0; c < TO - 1; c++) begin
      tick();
      @(negedge clock);
      chk("to_gnt_hold", 64'(bus.gnt), 64'd1);
    end
    tick();
    @(negedge clock);
    chk("to_gnt_idle", 64'(bus.gnt), 64'd0);
    tick();
    @(negedge clock);
    chk("to_gnt_moved", 64'(bus.gnt), 64'd2);
    wait_ack_drop(1);
    tick();
    release_m(0);
`else
    for (int c = 0; c < 16; c++) begin
      tick();
      @(negedge clock);
      chk("nto_gnt_hold", 64'(bus.gnt), 64'd1);
    end
    tick();
    release_m(0);
    @(negedge clock);
    chk("nto_gnt_drop", 64'(bus.gnt), 64'd1);
    tick();
    @(negedge clock);
    chk("nto_gnt_idle", 64'(bus.gnt), 64'd0);
    tick();
    @(negedge clock);
    chk("nto_gnt_moved", 64'(bus.gnt), 64'd2);
    wait_ack_drop(1);
`endif

    repeat (4) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
